// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for a debounced lock,
// then releases sys_rst; retries on timeout and relocks on loss.
module pll_lock_supervisor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 125000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int PW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] P_END = PW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_END = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] S_END = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_ASSERT = 3'b001,
    S_WAIT   = 3'b010,
    S_STABLE = 3'b011,
    S_RUN    = 3'b100,
    S_FAULT  = 3'b101
  } state_t;

  state_t        st_q, st_n;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [SW-1:0] stab, stab_n;
  logic [RW-1:0] retry, retry_n, retry_inc;
  logic [7:0]    relock_n, relock_inc;

  assign locked_s = sync_q[1];
  assign state    = st_q;

  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pll_locked};
  end

  assign retry_inc  = retry + RW'(1);
  assign relock_inc = (relock_count == 8'hFF) ?
                      relock_count : relock_count + 8'd1;

  always_comb begin
    st_n     = st_q;
    pcnt_n   = '0;
    tmr_n    = '0;
    stab_n   = '0;
    retry_n  = retry;
    relock_n = relock_count;
    if (force_relock) begin
      st_n    = S_ASSERT;
      retry_n = '0;
      // a loss of lock coinciding with the request still counts once
      if (st_q == S_RUN && !locked_s)
        relock_n = relock_inc;
    end else begin
      unique case (st_q)
        S_ASSERT: begin
          if (pcnt == P_END) st_n   = S_WAIT;
          else               pcnt_n = pcnt + PW'(1);
        end
        S_WAIT: begin
          if (locked_s) begin
            st_n = S_STABLE;
          end else if (tmr == T_END) begin
            retry_n = retry_inc;
            st_n    = (retry_inc == R_MAX) ? S_FAULT : S_ASSERT;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            st_n = S_WAIT;
          end else if (stab == S_END) begin
            st_n    = S_RUN;
            retry_n = '0;
          end else begin
            stab_n = stab + SW'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            st_n     = S_ASSERT;
            relock_n = relock_inc;
          end
        end
        S_FAULT: st_n = S_FAULT;
        default: st_n = S_ASSERT;
      endcase
    end
  end

  // outputs are registered decodes of the next state so they line up
  // with the state register itself
  always_ff @(posedge refclk) begin
    if (rst) begin
      st_q         <= S_ASSERT;
      pcnt         <= '0;
      tmr          <= '0;
      stab         <= '0;
      retry        <= '0;
      relock_count <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      st_q         <= st_n;
      pcnt         <= pcnt_n;
      tmr          <= tmr_n;
      stab         <= stab_n;
      retry        <= retry_n;
      relock_count <= relock_n;
      pll_rst      <= (st_n == S_ASSERT) || (st_n == S_FAULT);
      sys_rst      <= (st_n != S_RUN);
      ready        <= (st_n == S_RUN);
      fault        <= (st_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed/randomized bench for pll_lock_supervisor; expectations come
// from latency arithmetic and a saturating loss-of-lock counter model.
module tb_pll_lock_supervisor;

  localparam int R  = 4;
  localparam int T  = 50;
  localparam int LS = 8;
  localparam int MR = 3;
  localparam int SYNC = 2;

  localparam logic [2:0] ST_ASSERT = 3'b001;
  localparam logic [2:0] ST_WAIT   = 3'b010;
  localparam logic [2:0] ST_STABLE = 3'b011;
  localparam logic [2:0] ST_RUN    = 3'b100;
  localparam logic [2:0] ST_FAULT  = 3'b101;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int drops    = 0;
  int n, m, d, h;
  int st_at, wt_at, rd_at;

  pll_lock_supervisor #(
    .RST_CYCLES  (R),
    .LOCK_TIMEOUT(T),
    .LOCK_STABLE (LS),
    .MAX_RETRIES (MR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault       (fault),
    .relock_count(relock_count),
    .state       (state)
  );

  always #5 refclk = ~refclk;

  function automatic int exp_relock(input int k);
    return (k > 255) ? 255 : k;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int budget,
                            input string tag);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic pulse_len(output int k);
    k = 0;
    while (pll_rst === 1'b1 && k < 200) begin
      k++;
      tick();
    end
  endtask

  task automatic run_len(input logic [2:0] s, output int k);
    k = 0;
    while (state === s && k < 500) begin
      k++;
      tick();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(ST_ASSERT));
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_relock"}, 32'(relock_count), 0);
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    repeat (3) tick();
    chk_reset("por");

    // clean lock
    rst = 1'b0;
    pulse_len(n);
    chk("first_pulse", n, R);
    chk("wait_after_pulse", 32'(state), 32'(ST_WAIT));
    d = int'($urandom_range(20, 5));
    repeat (d) tick();
    pll_locked = 1'b1;
    st_at = 0;
    m = 0;
    while (ready !== 1'b1 && m < 100) begin
      tick();
      m++;
      if (state === ST_STABLE && st_at == 0) st_at = m;
    end
    chk("stable_latency", st_at, SYNC + 1);
    chk("ready_latency", m, SYNC + 1 + LS);
    chk("sys_rst_run", 32'(sys_rst), 0);
    chk("pll_rst_run", 32'(pll_rst), 0);

    // losses of lock in RUN
    for (int i = 0; i < 3; i++) begin
      repeat (int'($urandom_range(10, 1))) tick();
      pll_locked = 1'b0;
      drops++;
      m = 0;
      while (ready !== 1'b0 && m < 20) begin
        tick();
        m++;
      end
      chk("loss_latency", m, SYNC + 1);
      chk("loss_sys_rst", 32'(sys_rst), 1);
      chk("loss_pll_rst", 32'(pll_rst), 1);
      repeat (int'($urandom_range(30, 0))) tick();
      pll_locked = 1'b1;
      wait_state(ST_RUN, 200, "relock_run");
    end
    chk("relock_3", 32'(relock_count), exp_relock(drops));

    // force_relock in RUN, lock held
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("force_run_state", 32'(state), 32'(ST_ASSERT));
    chk("force_run_relock", 32'(relock_count), exp_relock(drops));
    wait_state(ST_RUN, 100, "force_run_back");

    // loss of lock and force_relock together
    pll_locked = 1'b0;
    tick();
    tick();
    chk("simul_pre_ready", 32'(ready), 1);
    force_relock = 1'b1;
    drops++;
    tick();
    force_relock = 1'b0;
    chk("simul_state", 32'(state), 32'(ST_ASSERT));
    chk("simul_relock", 32'(relock_count), exp_relock(drops));

    // glitchy lock
    wait_state(ST_WAIT, 20, "glitch_wait");
    h = int'($urandom_range(6, 1));
    pll_locked = 1'b1;
    st_at = 0;
    wt_at = 0;
    rd_at = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (state === ST_STABLE && st_at == 0) st_at = e;
      if (st_at != 0 && state === ST_WAIT && wt_at == 0) wt_at = e;
      if (ready === 1'b1 && rd_at == 0) rd_at = e;
      pll_locked = (e == h) ? 1'b0 : 1'b1;
      if (rd_at != 0) break;
    end
    chk("glitch_stable", st_at, SYNC + 1);
    chk("glitch_back_wait", wt_at, h + SYNC + 1);
    chk("glitch_ready", rd_at, h + 1 + SYNC + 1 + LS);

    // saturation of relock_count
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      drops++;
      wait_state(ST_ASSERT, 10, "sat_drop");
      pll_locked = 1'b1;
      wait_state(ST_RUN, 60, "sat_relock");
      chk("sat_count", 32'(relock_count), exp_relock(drops));
    end
    chk("sat_final", 32'(relock_count), 255);

    // rst during STABLE
    pll_locked = 1'b0;
    wait_state(ST_ASSERT, 10, "pre_stable_drop");
    pll_locked = 1'b1;
    wait_state(ST_STABLE, 40, "pre_stable");
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    chk_reset("rst_stable");
    rst = 1'b0;
    pulse_len(n);
    chk("rst_stable_pulse", n, R);
    chk("rst_stable_wait", 32'(state), 32'(ST_WAIT));

    // rst during WAIT_LOCK
    repeat (int'($urandom_range(30, 1))) tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_wait");
    rst = 1'b0;
    pulse_len(n);
    chk("rst_wait_pulse", n, R);

    // timeout retries into FAULT
    for (int k = 0; k < MR; k++) begin
      run_len(ST_WAIT, n);
      chk("timeout_len", n, T);
      if (k < MR - 1) begin
        pulse_len(n);
        chk("retry_pulse", n, R);
      end
    end
    chk("fault_state", 32'(state), 32'(ST_FAULT));
    chk("fault_flag", 32'(fault), 1);
    chk("fault_pll_rst", 32'(pll_rst), 1);
    chk("fault_sys_rst", 32'(sys_rst), 1);
    chk("fault_ready", 32'(ready), 0);
    repeat (int'($urandom_range(10, 1))) tick();
    chk("fault_hold", 32'(state), 32'(ST_FAULT));

    // force_relock out of FAULT
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("force_fault_state", 32'(state), 32'(ST_ASSERT));
    chk("force_fault_flag", 32'(fault), 0);
    chk("force_fault_relock", 32'(relock_count), 0);
    pulse_len(n);
    chk("force_fault_pulse", n, R);

    // lock arriving on the final timeout cycle wins
    repeat (T - 3) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    chk("edge_last_wait", 32'(state), 32'(ST_WAIT));
    tick();
    chk("edge_lock_wins", 32'(state), 32'(ST_STABLE));
    wait_state(ST_RUN, 20, "edge_run");
    chk("edge_ready", 32'(ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
